// File: rtl/axi_ram.sv
// AXI4 slave RAM of DEPTH 64-bit words mapped at byte address BASE.
// The write and read FSMs are independent; a read burst delivers one beat every two cycles.
module axi_ram #(
    parameter int          DEPTH = 8192,
    parameter logic [63:0] BASE  = 64'h8000_0000,
    parameter int          IDW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDW-1:0] s_axi_awid,
    input  logic [63:0]    s_axi_awaddr,
    input  logic [7:0]     s_axi_awlen,
    input  logic [2:0]     s_axi_awsize,
    input  logic [1:0]     s_axi_awburst,
    input  logic           s_axi_awvalid,
    output logic           s_axi_awready,
    input  logic [63:0]    s_axi_wdata,
    input  logic [7:0]     s_axi_wstrb,
    input  logic           s_axi_wlast,
    input  logic           s_axi_wvalid,
    output logic           s_axi_wready,
    output logic [IDW-1:0] s_axi_bid,
    output logic [1:0]     s_axi_bresp,
    output logic           s_axi_bvalid,
    input  logic           s_axi_bready,
    input  logic [IDW-1:0] s_axi_arid,
    input  logic [63:0]    s_axi_araddr,
    input  logic [7:0]     s_axi_arlen,
    input  logic [2:0]     s_axi_arsize,
    input  logic [1:0]     s_axi_arburst,
    input  logic           s_axi_arvalid,
    output logic           s_axi_arready,
    output logic [IDW-1:0] s_axi_rid,
    output logic [63:0]    s_axi_rdata,
    output logic [1:0]     s_axi_rresp,
    output logic           s_axi_rlast,
    output logic           s_axi_rvalid,
    input  logic           s_axi_rready
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_e;

    logic [63:0] mem [DEPTH];

    function automatic logic in_range(input logic [63:0] addr);
        return (addr >= BASE) && ((addr - BASE) < SPAN);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [63:0] addr);
        return AW'((addr - BASE) >> 3);
    endfunction

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'd3) ? 3'd3 : size;
    endfunction

    // WRAP keeps the low address bits inside a window of (len+1)<<size bytes; illegal WRAP lengths and burst 3 behave as INCR.
    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [63:0] inc;
        logic [63:0] mask;
        inc  = addr + (64'd1 << size);
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        if (burst == 2'b00)
            return addr;
        if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            return (addr & ~mask) | (inc & mask);
        return inc;
    endfunction

    w_state_e       w_state_q, w_state_d;
    logic [IDW-1:0] awid_q, awid_d;
    logic [63:0]    waddr_q, waddr_d;
    logic [7:0]     wlen_q, wlen_d;
    logic [2:0]     wsize_q, wsize_d;
    logic [1:0]     wburst_q, wburst_d;
    logic [7:0]     wcnt_q, wcnt_d;
    logic           decerr_q, decerr_d;
    logic           slverr_q, slverr_d;
    logic           mem_we;
    logic [AW-1:0]  widx;

    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        decerr_d  = decerr_q;
        slverr_d  = slverr_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (s_axi_awvalid) begin
                awid_d    = s_axi_awid;
                waddr_d   = s_axi_awaddr;
                wlen_d    = s_axi_awlen;
                wsize_d   = clamp_size(s_axi_awsize);
                wburst_d  = s_axi_awburst;
                wcnt_d    = 8'd0;
                decerr_d  = 1'b0;
                slverr_d  = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (s_axi_wvalid) begin
                mem_we = in_range(waddr_q);
                if (!in_range(waddr_q))
                    decerr_d = 1'b1;
                if (s_axi_wlast != (wcnt_q == wlen_q))
                    slverr_d = 1'b1;
                if (wcnt_q == wlen_q) begin
                    w_state_d = W_RESP;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                    waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                end
            end
            W_RESP: if (s_axi_bready)
                w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            decerr_q  <= 1'b0;
            slverr_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            decerr_q  <= decerr_d;
            slverr_q  <= slverr_d;
        end
    end

    assign widx = word_idx(waddr_q);

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++)
                if (s_axi_wstrb[b])
                    mem[widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
    end

    assign s_axi_awready = (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = awid_q;
    assign s_axi_bresp   = decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);

    r_state_e       r_state_q, r_state_d;
    logic [IDW-1:0] arid_q, arid_d;
    logic [63:0]    raddr_q, raddr_d;
    logic [7:0]     rlen_q, rlen_d;
    logic [2:0]     rsize_q, rsize_d;
    logic [1:0]     rburst_q, rburst_d;
    logic [7:0]     rcnt_q, rcnt_d;
    logic [63:0]    rdata_q, rdata_d;
    logic [1:0]     rresp_q, rresp_d;
    logic           rlast_q, rlast_d;

    // R_READ is the RAM access cycle; R_DATA presents the registered beat until it is taken.
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: if (s_axi_arvalid) begin
                arid_d    = s_axi_arid;
                raddr_d   = s_axi_araddr;
                rlen_d    = s_axi_arlen;
                rsize_d   = clamp_size(s_axi_arsize);
                rburst_d  = s_axi_arburst;
                rcnt_d    = 8'd0;
                r_state_d = R_READ;
            end
            R_READ: begin
                if (in_range(raddr_q)) begin
                    rdata_d = mem[word_idx(raddr_q)];
                    rresp_d = 2'b00;
                end else begin
                    rdata_d = 64'd0;
                    rresp_d = 2'b11;
                end
                rlast_d   = (rcnt_q == rlen_q);
                r_state_d = R_DATA;
            end
            R_DATA: if (s_axi_rready) begin
                rlast_d = 1'b0;
                if (rcnt_q == rlen_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    rcnt_d    = rcnt_q + 8'd1;
                    raddr_d   = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
                    r_state_d = R_READ;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rid     = arid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

endmodule

// File: doc/axi_ram.md
AXI_RAM -- requirements
Module: axi_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 8192, meaning memory size in 64-bit words (power of two).
REQ-002 SHALL have parameter BASE, default 64'h80000000, meaning byte address of word 0.
REQ-003 SHALL have parameter IDW, default 8, meaning AXI ID width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset (asserted at 0).
REQ-006 s_axi_awid  input  IDW  write burst ID.
REQ-007 s_axi_awaddr  input  64  write start byte address.
REQ-008 s_axi_awlen  input  8  write beats minus one.
REQ-009 s_axi_awsize  input  3  log2 bytes per beat.
REQ-010 s_axi_awburst  input  2  0 FIXED, 1 INCR, 2 WRAP.
REQ-011 s_axi_awvalid  input  1  AW valid.
REQ-012 s_axi_awready  output  1  AW ready.
REQ-013 s_axi_wdata  input  64  write data.
REQ-014 s_axi_wstrb  input  8  byte enables.
REQ-015 s_axi_wlast  input  1  last write beat.
REQ-016 s_axi_wvalid  input  1  W valid.
REQ-017 s_axi_wready  output  1  W ready.
REQ-018 s_axi_bid  output  IDW  response ID.
REQ-019 s_axi_bresp  output  2  write response.
REQ-020 s_axi_bvalid  output  1  B valid.
REQ-021 s_axi_bready  input  1  B ready.
REQ-022 s_axi_arid  input  IDW  read burst ID.
REQ-023 s_axi_araddr  input  64  read start byte address.
REQ-024 s_axi_arlen  input  8  read beats minus one.
REQ-025 s_axi_arsize  input  3  log2 bytes per beat.
REQ-026 s_axi_arburst  input  2  burst type, encoding as awburst.
REQ-027 s_axi_arvalid  input  1  AR valid.
REQ-028 s_axi_arready  output  1  AR ready.
REQ-029 s_axi_rid  output  IDW  read ID.
REQ-030 s_axi_rdata  output  64  read data.
REQ-031 s_axi_rresp  output  2  read response.
REQ-032 s_axi_rlast  output  1  last read beat.
REQ-033 s_axi_rvalid  output  1  R valid.
REQ-034 s_axi_rready  input  1  R ready.

Function
REQ-035 Write FSM SHALL be W_IDLE (awready=1) -> W_DATA on AW handshake (capture id/addr/len/size/burst, beat count 0) -> W_RESP after beat len accepted (wready=1 only in W_DATA) -> W_IDLE on bvalid&bready.
REQ-036 Read FSM SHALL be R_IDLE (arready=1) -> R_READ on AR handshake -> R_DATA one cycle later (synchronous RAM read, rvalid=1); on rvalid&rready go R_READ with next address, or R_IDLE after beat len; sustained rate one beat per 2 cycles.
REQ-037 Word index SHALL be ((addr-BASE)>>3); addr in range iff BASE <= addr < BASE+DEPTH*8; awsize/arsize >3 treated as 3; data always full aligned 64-bit word.
REQ-038 Next address SHALL be: FIXED unchanged; INCR addr+(1<<size); WRAP addr+(1<<size) wrapped within aligned window of (len+1)<<size bytes, WRAP with len not in {1,3,7,15} treated as INCR; reserved burst 3 treated as INCR.
REQ-039 Each accepted W beat SHALL update only bytes with wstrb=1; out-of-range beats SHALL NOT write.
REQ-040 bresp SHALL be 2'b11 (DECERR) if any beat out of range, else 2'b10 (SLVERR) if wlast mismatches final beat, else 2'b00; bid = captured awid.
REQ-041 Each R beat SHALL carry rid = captured arid, rlast=1 only on beat len, rresp 2'b00 in range, else rresp 2'b11 with rdata 0.
REQ-042 rdata/rresp/rlast/rid SHALL hold stable while rvalid=1 and rready=0; bid/bresp likewise while bvalid=1 and bready=0.
REQ-043 Read and write FSMs SHALL run independently; same-word read and write in same cycle SHALL return pre-write data.

Reset
REQ-044 On rst=0 (asynchronous): both FSMs idle; awready=arready=1; wready=bvalid=rvalid=rlast=0; bid=rid=0; bresp=rresp=0; rdata=0; memory contents not cleared; burst in progress abandoned without response.

Verification
REQ-045 AW 0x80000010 len0 size3 INCR id 5, W 0x1122334455667788 strb FF last -> bresp 0 bid 5; AR same -> rdata 0x1122334455667788 rlast 1 rresp 0.
REQ-046 Then write same address data 0xAAAAAAAABBBBBBBB strb 0F -> read returns 0x11223344BBBBBBBB.
REQ-047 INCR write len3 at 0x80000100 data 1,2,3,4; WRAP read len3 size3 at 0x80000110 -> rdata 3,4,1,2, rlast on 4th beat.
REQ-048 Write to BASE+DEPTH*8 -> bresp 2'b11, memory unchanged; read there -> rdata 0 rresp 2'b11; wlast high on beat 0 of len1 write -> bresp 2'b10.
REQ-049 rready low 5 cycles mid-burst -> R outputs stable; rst=0 mid read burst -> rvalid 0 immediately, arready 1, next burst served normally after release.
